// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the two-master memory arbiter.
// FSM encodings, bus widths and the default memory latency.
package cpu_bus_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 16;
    localparam int DEF_LATENCY = 1;
    localparam int CNT_W       = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker.
// On a tie the master not served last wins.
module arb_rr2
    import cpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |req;
    assign grant_idx   = (req == 2'b11) ? ~last_served : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter sequencing each access through a fixed wait count.
// Holds the FSM, wait counter, request latches and read-data registers.
module mem_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_write,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_write,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

    arb_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              owner_q;
    logic              last_served;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic grant_valid, grant_idx;
    logic grant, finish, in_access;

    arb_rr2 u_pick (
        .req         ({m1_req, m0_req}),
        .last_served (last_served),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            owner_q     <= 1'b0;
            last_served <= 1'b1;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state <= state_d;
            if (grant) begin
                addr_q      <= grant_idx ? m1_addr  : m0_addr;
                wdata_q     <= grant_idx ? m1_wdata : m0_wdata;
                write_q     <= grant_idx ? m1_write : m0_write;
                owner_q     <= grant_idx;
                last_served <= grant_idx;
                cnt         <= CNT_LOAD;
            end else if (in_access && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Read data is captured on the edge that leaves ACCESS.
            if (finish && !write_q) begin
                if (owner_q) rdata1_q <= mem_rdata;
                else         rdata0_q <= mem_rdata;
            end
        end
    end

    assign in_access = (state == ACCESS);

    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign mem_write = in_access && write_q && (cnt == CNT_LOAD);

    assign m0_ack   = (state == DONE) && !owner_q;
    assign m1_ack   = (state == DONE) &&  owner_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign owner    = owner_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at LATENCY 1, plus
// side instances at LATENCY 0 and 3 for the latency check.
module tb_mem_arbiter;

    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_req = 0, m0_write = 0, m1_req = 0, m1_write = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0;
    logic [15:0] m0_wdata = 0, m1_wdata = 0, mem_rdata = 0;
    logic        m0_ack, m1_ack, mem_write, owner, busy;
    logic [15:0] m0_rdata, m1_rdata, mem_wdata;
    logic [31:0] mem_addr;

    logic        zero1 = 1'b0;
    logic [31:0] zero32 = '0;
    logic [15:0] zero16 = '0;
    logic [31:0] side_addr = 32'h0000_1234;

    logic        z_req = 0, t_req = 0;
    logic [15:0] z_mrd = 16'haaaa, t_mrd = 16'hbbbb;
    logic        z_ack, z_ack1, z_wr, z_own, z_busy;
    logic        t_ack, t_ack1, t_wr, t_own, t_busy;
    logic [15:0] z_rd, z_rd1, z_wd, t_rd, t_rd1, t_wd;
    logic [31:0] z_addr, t_addr;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_write(m0_write), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_write(m1_write), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    mem_arbiter #(.LATENCY(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .m0_req(z_req), .m0_addr(side_addr), .m0_wdata(zero16),
        .m0_write(zero1), .m0_ack(z_ack), .m0_rdata(z_rd),
        .m1_req(zero1), .m1_addr(zero32), .m1_wdata(zero16),
        .m1_write(zero1), .m1_ack(z_ack1), .m1_rdata(z_rd1),
        .mem_addr(z_addr), .mem_wdata(z_wd),
        .mem_write(z_wr), .mem_rdata(z_mrd),
        .owner(z_own), .busy(z_busy)
    );

    mem_arbiter #(.LATENCY(3)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .m0_req(t_req), .m0_addr(side_addr), .m0_wdata(zero16),
        .m0_write(zero1), .m0_ack(t_ack), .m0_rdata(t_rd),
        .m1_req(zero1), .m1_addr(zero32), .m1_wdata(zero16),
        .m1_write(zero1), .m1_ack(t_ack1), .m1_rdata(t_rd1),
        .mem_addr(t_addr), .mem_wdata(t_wd),
        .mem_write(t_wr), .mem_rdata(t_mrd),
        .owner(t_own), .busy(t_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        int z_lat, t_lat;

        // reset state
        tick;
        check("rst_m0_ack", m0_ack, 0);
        check("rst_m1_ack", m1_ack, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick;

        // m0 read
        m0_req = 1; m0_addr = 32'hff00_0000; m0_write = 0;
        mem_rdata = 16'h1234;
        tick;
        check("rd_busy1", busy, 1);
        check("rd_owner1", owner, 0);
        check("rd_addr1", mem_addr, 32'hff00_0000);
        check("rd_wr1", mem_write, 0);
        tick;
        check("rd_addr2", mem_addr, 32'hff00_0000);
        check("rd_ack_early", m0_ack, 0);
        tick;
        check("rd_ack", m0_ack, 1);
        check("rd_rdata", m0_rdata, 16'h1234);
        check("rd_m1_ack", m1_ack, 0);
        check("rd_done_addr", mem_addr, 0);
        m0_req = 0;
        tick;
        check("rd_idle_busy", busy, 0);
        check("rd_ack_clr", m0_ack, 0);
        check("rd_rdata_hold", m0_rdata, 16'h1234);

        // m1 write
        m1_req = 1; m1_addr = 32'h0003_ffff;
        m1_wdata = 16'hbeef; m1_write = 1;
        mem_rdata = 16'hdead;
        tick;
        check("wr_write1", mem_write, 1);
        check("wr_wdata1", mem_wdata, 16'hbeef);
        check("wr_addr1", mem_addr, 32'h0003_ffff);
        check("wr_owner", owner, 1);
        tick;
        check("wr_write2", mem_write, 0);
        check("wr_wdata2", mem_wdata, 16'hbeef);
        tick;
        check("wr_ack", m1_ack, 1);
        check("wr_m0_ack", m0_ack, 0);
        check("wr_rdata", m1_rdata, 0);
        check("wr_done_write", mem_write, 0);
        m1_req = 0; m1_write = 0;
        tick;

        // tie right after reset, both held: grants 0,1,0,1
        rst_n = 0;
        tick;
        rst_n = 1;
        m0_addr = 32'h10; m1_addr = 32'h20;
        m0_req = 1; m1_req = 1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rr_owner", owner, k % 2);
            check("rr_addr", mem_addr, (k % 2) ? 32'h20 : 32'h10);
            tick;
            tick;
            check("rr_m0_ack", m0_ack, (k % 2) == 0);
            check("rr_m1_ack", m1_ack, (k % 2) == 1);
            if (k == 3) begin
                m0_req = 0; m1_req = 0;
            end
            tick;
            check("rr_idle", busy, 0);
        end

        // m1 arrives while m0 is in ACCESS
        m0_req = 1; m0_addr = 32'h100; mem_rdata = 16'h0f0f;
        tick;
        check("pend_owner0", owner, 0);
        m1_req = 1; m1_addr = 32'h200;
        tick;
        tick;
        check("pend_m0_ack", m0_ack, 1);
        check("pend_m1_wait", m1_ack, 0);
        check("pend_m0_rd", m0_rdata, 16'h0f0f);
        m0_req = 0; mem_rdata = 16'h5a5a;
        tick;
        check("pend_idle", busy, 0);
        tick;
        check("pend_owner1", owner, 1);
        check("pend_addr1", mem_addr, 32'h200);
        tick;
        check("pend_m1_early", m1_ack, 0);
        tick;
        check("pend_m1_ack", m1_ack, 1);
        check("pend_m1_rd", m1_rdata, 16'h5a5a);
        m1_req = 0;
        tick;

        // reset in the second ACCESS cycle of a read
        m0_req = 1; m0_addr = 32'h300; mem_rdata = 16'h7777;
        tick;
        tick;
        #2 rst_n = 0;
        m0_req = 0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_addr", mem_addr, 0);
        check("ar_ack", m0_ack, 0);
        check("ar_rdata", m0_rdata, 0);
        check("ar_m1_rdata", m1_rdata, 0);
        check("ar_owner", owner, 0);
        tick;
        check("ar_hold_ack", m0_ack, 0);
        rst_n = 1;
        tick;
        m0_req = 1; m0_addr = 32'h400; mem_rdata = 16'h4242;
        tick;
        check("ar2_addr", mem_addr, 32'h400);
        tick;
        tick;
        check("ar2_ack", m0_ack, 1);
        check("ar2_rdata", m0_rdata, 16'h4242);
        m0_req = 0;
        tick;

        // LATENCY 0 and 3 request-to-ack spacing
        z_lat = 0; t_lat = 0;
        z_req = 1; t_req = 1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (z_busy && !z_ack) check("lat0_addr", z_addr, 32'h1234);
            if (t_busy && !t_ack) check("lat3_addr", t_addr, 32'h1234);
            if (z_ack && z_lat == 0) begin
                z_lat = c; z_req = 0;
            end
            if (t_ack && t_lat == 0) begin
                t_lat = c; t_req = 0;
            end
        end
        z_req = 0; t_req = 0;
        check("lat0_cycles", z_lat, 2);
        check("lat3_cycles", t_lat, 5);
        check("lat0_rdata", z_rd, 16'haaaa);
        check("lat3_rdata", t_rd, 16'hbbbb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
